// File: rtl/volley_score_engine.sv
// Point/set engine for one volleyball match: scores, set awards, undo stack
// and match completion, all in a single clock domain.
module volley_score_engine #(
  parameter int PNT_W         = 5,
  parameter int TARGET_NORMAL = 25,
  parameter int TARGET_TB     = 15,
  parameter int MARGIN        = 2,
  parameter int SETS_TO_WIN   = 3,
  parameter int HIST_DEPTH    = 8,
  localparam int SET_W        = $clog2(SETS_TO_WIN + 1),
  localparam int CNT_W        = $clog2(HIST_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pnt_a_inc,
  input  logic             pnt_b_inc,
  input  logic             undo,
  input  logic             mode25_15,
  output logic [PNT_W-1:0] pnt_a,
  output logic [PNT_W-1:0] pnt_b,
  output logic [SET_W-1:0] set_a,
  output logic [SET_W-1:0] set_b,
  output logic             RCOpnt_a,
  output logic             RCOpnt_b,
  output logic             serve_b,
  output logic [CNT_W-1:0] hist_cnt,
  output logic             match_over,
  output logic             winner_b,
  output logic             err,
  output logic [1:0]       state_dbg
);

  localparam int PTR_W = $clog2(HIST_DEPTH);
  localparam int EXT_W = PNT_W + 2;

  typedef enum logic [1:0] {
    ST_PLAY       = 2'd0,
    ST_SET_END    = 2'd1,
    ST_MATCH_OVER = 2'd2
  } state_e;

  // Inputs are single-cycle pulses with no back-pressure: every asserted
  // pulse is either applied in that cycle or rejected with a one-cycle err.
  state_e                state_q, state_d;
  logic [PNT_W-1:0]      pnt_a_q, pnt_a_d, pnt_b_q, pnt_b_d;
  logic [SET_W-1:0]      set_a_q, set_a_d, set_b_q, set_b_d;
  logic                  rco_a_q, rco_a_d, rco_b_q, rco_b_d;
  logic                  serve_b_q, serve_b_d, winner_b_q, winner_b_d;
  logic                  err_q, err_d;
  logic [HIST_DEPTH-1:0] hist_q, hist_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      hist_cnt_q, hist_cnt_d;

  logic [PNT_W-1:0]      mine, other;
  logic [EXT_W-1:0]      new_pnt, target;
  logic [PTR_W-1:0]      ptr_m1, ptr_m2;
  logic                  tb_set, any_in;

  always_comb begin
    state_d    = state_q;
    pnt_a_d    = pnt_a_q;
    pnt_b_d    = pnt_b_q;
    set_a_d    = set_a_q;
    set_b_d    = set_b_q;
    rco_a_d    = 1'b0;
    rco_b_d    = 1'b0;
    serve_b_d  = serve_b_q;
    winner_b_d = winner_b_q;
    err_d      = 1'b0;
    hist_d     = hist_q;
    wr_ptr_d   = wr_ptr_q;
    hist_cnt_d = hist_cnt_q;

    any_in  = pnt_a_inc | pnt_b_inc | undo;
    mine    = pnt_b_inc ? pnt_b_q : pnt_a_q;
    other   = pnt_b_inc ? pnt_a_q : pnt_b_q;
    new_pnt = EXT_W'(mine) + EXT_W'(1);
    tb_set  = mode25_15 ||
              (set_a_q == SET_W'(SETS_TO_WIN - 1) && set_b_q == SET_W'(SETS_TO_WIN - 1));
    target  = tb_set ? EXT_W'(TARGET_TB) : EXT_W'(TARGET_NORMAL);
    ptr_m1  = wr_ptr_q - PTR_W'(1);
    ptr_m2  = wr_ptr_q - PTR_W'(2);

    case (state_q)
      ST_PLAY: begin
        if (undo) begin
          if (pnt_a_inc || pnt_b_inc) err_d = 1'b1;
          if (hist_cnt_q == '0) begin
            err_d = 1'b1;
          end else begin
            if (hist_q[ptr_m1]) pnt_b_d = pnt_b_q - PNT_W'(1);
            else                pnt_a_d = pnt_a_q - PNT_W'(1);
            wr_ptr_d   = ptr_m1;
            hist_cnt_d = hist_cnt_q - CNT_W'(1);
            serve_b_d  = (hist_cnt_q > CNT_W'(1)) ? hist_q[ptr_m2] : 1'b0;
          end
        end else if (pnt_a_inc && pnt_b_inc) begin
          err_d = 1'b1;
        end else if (pnt_a_inc || pnt_b_inc) begin
          if (mine == {PNT_W{1'b1}}) begin
            err_d = 1'b1;
          end else begin
            if (pnt_b_inc) pnt_b_d = new_pnt[PNT_W-1:0];
            else           pnt_a_d = new_pnt[PNT_W-1:0];
            serve_b_d        = pnt_b_inc;
            hist_d[wr_ptr_q] = pnt_b_inc;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            if (hist_cnt_q != CNT_W'(HIST_DEPTH)) hist_cnt_d = hist_cnt_q + CNT_W'(1);
            // Lead is checked as new >= other + MARGIN to stay unsigned.
            if (new_pnt >= target && new_pnt >= EXT_W'(other) + EXT_W'(MARGIN)) begin
              state_d = ST_SET_END;
              if (pnt_b_inc) begin
                rco_b_d = 1'b1;
                set_b_d = set_b_q + SET_W'(1);
              end else begin
                rco_a_d = 1'b1;
                set_a_d = set_a_q + SET_W'(1);
              end
            end
          end
        end
      end
      ST_SET_END: begin
        err_d      = any_in;
        pnt_a_d    = '0;
        pnt_b_d    = '0;
        serve_b_d  = 1'b0;
        wr_ptr_d   = '0;
        hist_cnt_d = '0;
        if (set_a_q == SET_W'(SETS_TO_WIN) || set_b_q == SET_W'(SETS_TO_WIN)) begin
          state_d    = ST_MATCH_OVER;
          winner_b_d = (set_b_q == SET_W'(SETS_TO_WIN));
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_MATCH_OVER: err_d = any_in;
      default:       state_d = ST_PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_PLAY;
      pnt_a_q    <= '0;
      pnt_b_q    <= '0;
      set_a_q    <= '0;
      set_b_q    <= '0;
      rco_a_q    <= 1'b0;
      rco_b_q    <= 1'b0;
      serve_b_q  <= 1'b0;
      winner_b_q <= 1'b0;
      err_q      <= 1'b0;
      hist_q     <= '0;
      wr_ptr_q   <= '0;
      hist_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pnt_a_q    <= pnt_a_d;
      pnt_b_q    <= pnt_b_d;
      set_a_q    <= set_a_d;
      set_b_q    <= set_b_d;
      rco_a_q    <= rco_a_d;
      rco_b_q    <= rco_b_d;
      serve_b_q  <= serve_b_d;
      winner_b_q <= winner_b_d;
      err_q      <= err_d;
      hist_q     <= hist_d;
      wr_ptr_q   <= wr_ptr_d;
      hist_cnt_q <= hist_cnt_d;
    end
  end

  assign pnt_a      = pnt_a_q;
  assign pnt_b      = pnt_b_q;
  assign set_a      = set_a_q;
  assign set_b      = set_b_q;
  assign RCOpnt_a   = rco_a_q;
  assign RCOpnt_b   = rco_b_q;
  assign serve_b    = serve_b_q;
  assign hist_cnt   = hist_cnt_q;
  assign match_over = (state_q == ST_MATCH_OVER);
  assign winner_b   = winner_b_q;
  assign err        = err_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/volley_score_engine.md
Name: volley_score_engine

Overview:
Parameterised single-clock point/set engine for one volleyball match. It is the successor to the two-counter point block, which had split clocks and per-team backups. It tracks points for teams A and B, applies the target and win-by-margin rules, and awards sets. It selects the deciding-set target automatically, supports multi-level undo through a scorer history stack, and flags match completion. It sits between the debounced button/strobe logic and the 7-segment display drivers.

Parameters:
PNT_W, 5, point counter width; max representable score 2^PNT_W-1
TARGET_NORMAL, 25, points needed in a normal set
TARGET_TB, 15, points needed in the deciding (tie-break) set
MARGIN, 2, minimum lead required to win a set
SETS_TO_WIN, 3, sets needed to win the match
HIST_DEPTH, 8, undo history entries (power of two)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pnt_a_inc  in  1  one-cycle pulse: team A scores
pnt_b_inc  in  1  one-cycle pulse: team B scores
undo  in  1  one-cycle pulse: revert last point
mode25_15  in  1  1 = force TARGET_TB for the current set
pnt_a  out  PNT_W  team A points
pnt_b  out  PNT_W  team B points
set_a  out  SET_W  team A sets won; SET_W = $clog2(SETS_TO_WIN+1)
set_b  out  SET_W  team B sets won
RCOpnt_a  out  1  one-cycle pulse: A won a set
RCOpnt_b  out  1  one-cycle pulse: B won a set
serve_b  out  1  last scorer/serving team (0 = A, 1 = B)
hist_cnt  out  $clog2(HIST_DEPTH+1)  valid undo entries
match_over  out  1  match finished
winner_b  out  1  valid when match_over; 1 = B won
err  out  1  one-cycle pulse: input rejected

Behaviour:
- Reset (rst=1 at a clk edge, any state): all outputs 0, history empty, state PLAY. Reset mid-set or mid-SET_END discards everything.
- States: PLAY, SET_END, MATCH_OVER.
- Target: target = TARGET_TB if mode25_15=1 or (set_a==SETS_TO_WIN-1 and set_b==SETS_TO_WIN-1); otherwise TARGET_NORMAL. Evaluated in the cycle of the increment.
- PLAY, input priority per cycle:
  1) undo
  2) single increment
  3) pnt_a_inc and pnt_b_inc together: rejected, err=1, no change
- Increment, team X:
  - pnt_X+1 registered (visible next cycle); serve_b updated.
  - Scorer bit pushed onto history. When hist_cnt==HIST_DEPTH, the oldest entry is overwritten and hist_cnt stays at HIST_DEPTH.
  - pnt_X saturates at 2^PNT_W-1: the increment is ignored and err=1.
- Set-win check uses the new score: new_X >= target and new_X - pnt_other >= MARGIN. On a win:
  - Next cycle: state SET_END, pnt shows the final score, RCOpnt_X=1 for exactly 1 cycle, set_X increments.
- Undo in PLAY:
  - hist_cnt==0: ignored, err=1.
  - Otherwise pop the top entry, decrement that team's points, hist_cnt-1, and set serve_b to the new top entry (0 if the stack is now empty).
  - Undo together with an increment: undo performed, increment dropped, err=1.
- SET_END (exactly 1 cycle): points and history cleared.
  - Next state is MATCH_OVER if set_X==SETS_TO_WIN, else PLAY.
  - All inputs in this cycle are ignored (err=1 if any was asserted).
- MATCH_OVER: match_over=1, winner_b held. Points stay 0, set counts are held. All inputs ignored; only rst exits.
- No undo across a set boundary.
- Input-to-output latency for pnt: 1 clock.

Test Plan:
1. Reset, then 25 A-pulses interleaved with 23 B-pulses (B finishes first) -> after the 25th A pulse: pnt_a=25, pnt_b=23, RCOpnt_a high 1 cycle, set_a=1; next cycle pnt_a=pnt_b=0, hist_cnt=0.
2. Deuce: reach 24-24, then A, B, A, A -> no RCO at 25-24 or 25-25; 27-25 gives RCOpnt_a and set_a+1.
3. Undo depth: 10 A-pulses then 9 undos -> pnt_a=2 and hist_cnt=0 after the 8th undo; the 9th undo gives err=1 with pnt_a unchanged at 2.
4. Tie-break: sets 2-2, B reaches 15-13 -> RCOpnt_b, set_b=3, then match_over=1, winner_b=1; further pulses give err, no count change.
5. Simultaneous pnt_a_inc and pnt_b_inc at 3-3 -> err=1, score stays 3-3; undo together with pnt_b_inc at 4-3 (last scorer A) -> 3-3, err=1.
6. rst asserted in the SET_END cycle and at 12-10 -> all outputs 0 next cycle, state PLAY; with mode25_15=1 at sets 0-0, 15-13 wins the set.
